// File: rtl/ct_f_spsram_pkg.sv
// Shared definitions for the self-clearing single-port SRAM: clear FSM encoding
// and read-latency constants.
package ct_f_spsram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } init_state_e;

    localparam int unsigned RD_LAT_DIRECT = 32'd1;
    localparam int unsigned RD_LAT_OUTREG = 32'd2;

    function automatic int unsigned rd_latency(input int out_reg);
        if (out_reg != 32'sd0) begin
            return RD_LAT_OUTREG;
        end else begin
            return RD_LAT_DIRECT;
        end
    endfunction

endpackage

// File: rtl/ct_f_spsram_init_ctrl.sv
// Clear FSM, clear address counter and access mux choosing between the user
// port and the zero-fill sweep.
module ct_f_spsram_init_ctrl
    import ct_f_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 144,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [DATA_WIDTH-1:0] mem_wen_n,
    output logic                  rd_en,
    output logic                  clear_start,
    output logic                  init_busy
);

    localparam logic                  INIT_ON   = (INIT_EN != 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    init_state_e           state_r;
    init_state_e           state_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  pend_r;
    logic                  busy_r;
    logic                  start_s;

    // next-state logic; pend_r carries the "clear after reset release" request
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (INIT_ON && (pend_r || INIT_REQ)) begin
                    state_s = ST_CLEAR;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_r == LAST_ADDR) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, sweep counter and registered busy flag
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_r <= ST_IDLE;
            cnt_r   <= {ADDR_WIDTH{1'b0}};
            pend_r  <= INIT_ON;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pend_r  <= 1'b0;
            busy_r  <= (state_s == ST_CLEAR);
            if (start_s) begin
                cnt_r <= {ADDR_WIDTH{1'b0}};
            end else if ((state_r == ST_CLEAR) && (cnt_r != LAST_ADDR)) begin
                cnt_r <= cnt_r + ADDR_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // the sweep owns the array completely; user accesses are dropped meanwhile
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = A;
        mem_din   = D;
        mem_wen_n = WEN;
        rd_en     = 1'b0;
        if (state_r == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_r;
            mem_din   = {DATA_WIDTH{1'b0}};
            mem_wen_n = {DATA_WIDTH{1'b0}};
            rd_en     = 1'b0;
        end else begin
            mem_we    = ~CEN & ~GWEN;
            mem_addr  = A;
            mem_din   = D;
            mem_wen_n = WEN;
            rd_en     = ~CEN & GWEN;
        end
    end

    assign clear_start = start_s;
    assign init_busy   = busy_r;

endmodule

// File: rtl/fpga_ram.sv
// Per-bit RAM primitive: synchronous write, asynchronous read, WRAP_SIZE bits wide.
module fpga_ram #(
    parameter int WRAP_SIZE  = 1,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [WRAP_SIZE-1:0]  din,
    output logic [WRAP_SIZE-1:0]  dout
);

    logic [WRAP_SIZE-1:0] mem_r [2**ADDR_WIDTH];

    // array write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    assign dout = mem_r[addr];

endmodule

// File: rtl/ct_f_spsram_init.sv
// Single-port SRAM built from per-bit RAM primitives, with automatic zero-clear
// after reset and on request, and a configurable 1- or 2-cycle read latency.
module ct_f_spsram_init
    import ct_f_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 144,
    parameter int WRAP_SIZE  = 1,
    parameter int OUT_REG    = 0,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  RD_VLD,
    output logic                  INIT_BUSY
);

    localparam int unsigned RD_LAT = rd_latency(OUT_REG);

    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_din_s;
    logic [DATA_WIDTH-1:0] mem_wen_n_s;
    logic                  rd_en_s;
    logic                  clear_start_s;
    logic [DATA_WIDTH-1:0] bit_we_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic [WRAP_SIZE-1:0]  ram_q_s [DATA_WIDTH];
    logic                  out_vld_s;
    logic [DATA_WIDTH-1:0] out_data_s;
    logic [DATA_WIDTH-1:0] q_r;
    logic                  rd_vld_r;

    ct_f_spsram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_EN    (INIT_EN)
    ) u_ctrl (
        .CLK         (CLK),
        .cpurst_b    (cpurst_b),
        .A           (A),
        .CEN         (CEN),
        .GWEN        (GWEN),
        .WEN         (WEN),
        .D           (D),
        .INIT_REQ    (INIT_REQ),
        .mem_we      (mem_we_s),
        .mem_addr    (mem_addr_s),
        .mem_din     (mem_din_s),
        .mem_wen_n   (mem_wen_n_s),
        .rd_en       (rd_en_s),
        .clear_start (clear_start_s),
        .init_busy   (INIT_BUSY)
    );

    assign bit_we_s = {DATA_WIDTH{mem_we_s}} & ~mem_wen_n_s;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        fpga_ram #(
            .WRAP_SIZE  (WRAP_SIZE),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ram (
            .clk  (CLK),
            .addr (mem_addr_s),
            .we   (bit_we_s[i]),
            .din  ({WRAP_SIZE{mem_din_s[i]}}),
            .dout (ram_q_s[i])
        );
        assign rd_word_s[i] = ram_q_s[i][0];
    end

    if (RD_LAT == RD_LAT_OUTREG) begin : g_outreg
        logic                  p1_vld_r;
        logic [DATA_WIDTH-1:0] p1_data_r;

        // extra pipeline stage; a clear starting now kills the pending read
        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                p1_vld_r  <= 1'b0;
                p1_data_r <= {DATA_WIDTH{1'b0}};
            end else begin
                p1_vld_r <= rd_en_s & ~clear_start_s;
                if (rd_en_s) begin
                    p1_data_r <= rd_word_s;
                end else begin
                    p1_data_r <= p1_data_r;
                end
            end
        end

        assign out_vld_s  = p1_vld_r & ~clear_start_s;
        assign out_data_s = p1_data_r;
    end else begin : g_direct
        assign out_vld_s  = rd_en_s & ~clear_start_s;
        assign out_data_s = rd_word_s;
    end

    // Q only moves together with RD_VLD
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            q_r      <= {DATA_WIDTH{1'b0}};
            rd_vld_r <= 1'b0;
        end else begin
            rd_vld_r <= out_vld_s;
            if (out_vld_s) begin
                q_r <= out_data_s;
            end else begin
                q_r <= q_r;
            end
        end
    end

    assign Q      = q_r;
    assign RD_VLD = rd_vld_r;

endmodule

// File: tb/tb_ct_f_spsram_init.sv
// Directed bench: two instances (OUT_REG=0 and OUT_REG=1) share one stimulus stream.
module tb_ct_f_spsram_init;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] ONES  = 16'hFFFF;
    localparam logic [DW-1:0] ZEROS = 16'h0000;

    logic          CLK;
    logic          cpurst_b;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;
    logic          INIT_REQ;
    logic [DW-1:0] q0, q1;
    logic          v0, v1, b0, b1;

    int checks;
    int failures;

    ct_f_spsram_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(1), .OUT_REG(0), .INIT_EN(1)) dut0 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .INIT_REQ(INIT_REQ), .Q(q0), .RD_VLD(v0), .INIT_BUSY(b0)
    );

    ct_f_spsram_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(1), .OUT_REG(1), .INIT_EN(1)) dut1 (
        .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .INIT_REQ(INIT_REQ), .Q(q1), .RD_VLD(v1), .INIT_BUSY(b1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        CEN = 1'b1; GWEN = 1'b1; WEN = ONES; D = ZEROS; A = 4'd0; INIT_REQ = 1'b0;
    endtask

    task automatic drive_read(input logic [AW-1:0] addr);
        CEN = 1'b0; GWEN = 1'b1; WEN = ONES; D = ZEROS; A = addr; INIT_REQ = 1'b0;
    endtask

    task automatic drive_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [DW-1:0] wen_n);
        CEN = 1'b0; GWEN = 1'b0; WEN = wen_n; D = data; A = addr; INIT_REQ = 1'b0;
    endtask

    task automatic test_reset();
        cpurst_b = 1'b1;
        drive_idle();
        #1 cpurst_b = 1'b0;
        #1;
        checks += 6;
        if (q0 !== ZEROS) begin failures++; $display("FAIL reset_q0 got %h want %h", q0, ZEROS); end
        if (v0 !== 1'b0)  begin failures++; $display("FAIL reset_v0 got %b want 0", v0); end
        if (b0 !== 1'b0)  begin failures++; $display("FAIL reset_b0 got %b want 0", b0); end
        if (q1 !== ZEROS) begin failures++; $display("FAIL reset_q1 got %h want %h", q1, ZEROS); end
        if (v1 !== 1'b0)  begin failures++; $display("FAIL reset_v1 got %b want 0", v1); end
        if (b1 !== 1'b0)  begin failures++; $display("FAIL reset_b1 got %b want 0", b1); end
    endtask

    // releases reset and measures the length of the power-up clear
    task automatic test_powerup_clear();
        int c0, c1;
        c0 = 0; c1 = 0;
        @(posedge CLK);
        #1 cpurst_b = 1'b1;
        step();
        checks++;
        if (b0 !== 1'b1) begin failures++; $display("FAIL busy_first_clock got %b want 1", b0); end
        if (b0) c0++;
        if (b1) c1++;
        for (int k = 0; k < 40; k++) begin
            step();
            if (v0 !== 1'b0 || v1 !== 1'b0) begin
                checks++; failures++;
                $display("FAIL vld_during_clear got %b%b want 00", v0, v1);
            end
            if (b0) c0++;
            if (b1) c1++;
            if (!b0 && !b1) break;
        end
        checks += 2;
        if (c0 != DEPTH) begin failures++; $display("FAIL busy_len0 got %0d want %0d", c0, DEPTH); end
        if (c1 != DEPTH) begin failures++; $display("FAIL busy_len1 got %0d want %0d", c1, DEPTH); end
    endtask

    // back-to-back reads of every word, each expected to be zero
    task automatic test_all_zero(input string tag);
        for (int i = 0; i <= DEPTH; i++) begin
            if (i < DEPTH) drive_read(AW'(i)); else drive_idle();
            step();
            checks += 2;
            if (v0 !== (i < DEPTH) || (i < DEPTH && q0 !== ZEROS)) begin
                failures++;
                $display("FAIL %s_rd0 i=%0d got v=%b q=%h want v=%b q=%h", tag, i, v0, q0, (i < DEPTH), ZEROS);
            end
            if (v1 !== (i >= 1) || (i >= 1 && q1 !== ZEROS)) begin
                failures++;
                $display("FAIL %s_rd1 i=%0d got v=%b q=%h want v=%b q=%h", tag, i, v1, q1, (i >= 1), ZEROS);
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_write_read();
        drive_write(4'd3, ONES, ZEROS);
        step();
        drive_read(4'd3);
        step();
        checks += 3;
        if (v0 !== 1'b1 || q0 !== ONES) begin failures++; $display("FAIL wr_rd0 got v=%b q=%h want v=1 q=%h", v0, q0, ONES); end
        if (v1 !== 1'b0) begin failures++; $display("FAIL wr_rd1_early got v=%b want 0", v1); end
        if (q1 !== ZEROS) begin failures++; $display("FAIL wr_rd1_q_early got %h want %h", q1, ZEROS); end
        drive_idle();
        step();
        checks += 2;
        if (v1 !== 1'b1 || q1 !== ONES) begin failures++; $display("FAIL wr_rd1 got v=%b q=%h want v=1 q=%h", v1, q1, ONES); end
        if (v0 !== 1'b0 || q0 !== ONES) begin failures++; $display("FAIL wr_rd0_hold got v=%b q=%h want v=0 q=%h", v0, q0, ONES); end
    endtask

    task automatic test_bit_mask();
        drive_write(4'd5, ONES, 16'hFF00);
        step();
        drive_read(4'd5);
        step();
        checks++;
        if (v0 !== 1'b1 || q0 !== 16'h00FF) begin failures++; $display("FAIL mask_rd0 got v=%b q=%h want v=1 q=00ff", v0, q0); end
        drive_idle();
        step();
        checks++;
        if (v1 !== 1'b1 || q1 !== 16'h00FF) begin failures++; $display("FAIL mask_rd1 got v=%b q=%h want v=1 q=00ff", v1, q1); end
    endtask

    // read, two idles, then a write: Q must hold and RD_VLD pulse exactly once
    task automatic test_hold();
        int p0, p1;
        p0 = 0; p1 = 0;
        drive_read(4'd3);
        step();
        if (v0) p0++;
        if (v1) p1++;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) drive_write(4'd3, ZEROS, ZEROS); else drive_idle();
            step();
            if (v0) p0++;
            if (v1) p1++;
            checks += 2;
            if (q0 !== ONES) begin failures++; $display("FAIL hold_q0 k=%0d got %h want %h", k, q0, ONES); end
            if (q1 !== ONES) begin failures++; $display("FAIL hold_q1 k=%0d got %h want %h", k, q1, ONES); end
        end
        drive_idle();
        step();
        if (v0) p0++;
        if (v1) p1++;
        checks += 2;
        if (p0 != 1) begin failures++; $display("FAIL hold_pulses0 got %0d want 1", p0); end
        if (p1 != 1) begin failures++; $display("FAIL hold_pulses1 got %0d want 1", p1); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_tbl [4];
        for (int i = 0; i < 4; i++) begin
            exp_tbl[i] = 16'hA5C0 + DW'(i * 16'h0111);
            drive_write(AW'(8 + i), exp_tbl[i], ZEROS);
            step();
        end
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive_read(AW'(8 + i)); else drive_idle();
            step();
            checks += 2;
            if (i < 4 && (v0 !== 1'b1 || q0 !== exp_tbl[i])) begin
                failures++; $display("FAIL b2b_rd0 i=%0d got v=%b q=%h want v=1 q=%h", i, v0, q0, exp_tbl[i]);
            end else if (i == 4 && v0 !== 1'b0) begin
                failures++; $display("FAIL b2b_rd0_end got v=%b want 0", v0);
            end
            if (i >= 1 && (v1 !== 1'b1 || q1 !== exp_tbl[i-1])) begin
                failures++; $display("FAIL b2b_rd1 i=%0d got v=%b q=%h want v=1 q=%h", i, v1, q1, exp_tbl[i-1]);
            end else if (i == 0 && v1 !== 1'b0) begin
                failures++; $display("FAIL b2b_rd1_start got v=%b want 0", v1);
            end
        end
        drive_idle();
        step();
    endtask

    // clear on request: pending read in dut1's pipe is flushed, writes/INIT_REQ during clear dropped
    task automatic test_init_req();
        int c0;
        c0 = 0;
        drive_read(4'd8);
        step();
        checks++;
        if (v0 !== 1'b1 || q0 !== 16'hA5C0) begin failures++; $display("FAIL pre_clear_rd0 got v=%b q=%h want v=1 q=a5c0", v0, q0); end
        drive_idle();
        INIT_REQ = 1'b1;
        step();
        checks += 3;
        if (b0 !== 1'b1) begin failures++; $display("FAIL req_busy got %b want 1", b0); end
        if (v1 !== 1'b0) begin failures++; $display("FAIL flush_v1 got %b want 0", v1); end
        if (q1 === 16'hA5C0) begin failures++; $display("FAIL flush_q1 got %h want previous value", q1); end
        c0 = 1;
        drive_write(4'd9, ONES, ZEROS);
        INIT_REQ = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            drive_idle();
            if (v0 !== 1'b0 || v1 !== 1'b0) begin
                checks++; failures++; $display("FAIL req_vld_during_clear got %b%b want 00", v0, v1);
            end
            if (b0) c0++; else break;
        end
        checks++;
        if (c0 != DEPTH) begin failures++; $display("FAIL req_busy_len got %0d want %0d", c0, DEPTH); end
        test_all_zero("req");
    endtask

    task automatic test_reset_mid_clear();
        int c0;
        c0 = 0;
        drive_write(4'd2, ONES, ZEROS);
        step();
        drive_idle();
        INIT_REQ = 1'b1;
        step();
        drive_idle();
        for (int k = 0; k < 7; k++) step();
        #1 cpurst_b = 1'b0;
        #1;
        checks += 4;
        if (b0 !== 1'b0 || b1 !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b%b want 00", b0, b1); end
        if (v0 !== 1'b0 || v1 !== 1'b0) begin failures++; $display("FAIL midrst_vld got %b%b want 00", v0, v1); end
        if (q0 !== ZEROS) begin failures++; $display("FAIL midrst_q0 got %h want %h", q0, ZEROS); end
        if (q1 !== ZEROS) begin failures++; $display("FAIL midrst_q1 got %h want %h", q1, ZEROS); end
        #1 cpurst_b = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (b0) c0++; else if (c0 > 0) break;
        end
        checks++;
        if (c0 != DEPTH) begin failures++; $display("FAIL midrst_busy_len got %0d want %0d", c0, DEPTH); end
        test_all_zero("midrst");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_powerup_clear();
        test_all_zero("pwrup");
        test_write_read();
        test_bit_mask();
        test_hold();
        test_back_to_back();
        test_init_req();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
